// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative RV32M multiplier.
// The optional product-reuse path is enabled by defining MUL_PRODUCT_REUSE_EN.
package mul_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SIGN = 2'b10,
      DONE = 2'b11
   } mul_state_e;

   // rs1 is treated as signed for MULH and MULHSU
   function automatic logic op_a_signed(input mul_op_e op);
      return (op == MULH) || (op == MULHSU);
   endfunction

   // rs2 is treated as signed for MULH only
   function automatic logic op_b_signed(input mul_op_e op);
      return (op == MULH);
   endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One iteration of the radix multiplier: adds |a| x b_chunk, shifted to the
// weight of the current chunk, into the full-width accumulator.
module mul_radix_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int CW             = 6
) (
   input  logic [2*XLEN-1:0]         acc,
   input  logic [XLEN-1:0]           a_mag,
   input  logic [BITS_PER_CYCLE-1:0] b_chunk,
   input  logic [CW-1:0]             count,
   output logic [2*XLEN-1:0]         acc_next
);

   localparam int PW = XLEN + BITS_PER_CYCLE;

   logic [PW-1:0]     term [BITS_PER_CYCLE];
   logic [PW-1:0]     partial;
   logic [2*XLEN-1:0] partial_ext;

   // one shifted copy of |a| per chunk bit, gated by that bit
   for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = b_chunk[gi] ? (PW'(a_mag) << gi) : '0;
   end

   // |a| x b_chunk never exceeds XLEN+BITS_PER_CYCLE bits, so no truncation here
   always_comb begin
      partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         partial = partial + term[i];
      end
   end

   assign partial_ext = (2*XLEN)'(partial);
   assign acc_next    = acc + (partial_ext << (count * BITS_PER_CYCLE));

endmodule

// File: rtl/mul_iterative_radix.sv
// Iterative sign-magnitude multiplier for MUL/MULH/MULHSU/MULHU.
// Retires BITS_PER_CYCLE multiplier bits per clock; latency K+2 with K=XLEN/BITS_PER_CYCLE.
// Define MUL_PRODUCT_REUSE_EN to return a stored product when operands repeat.
module mul_iterative_radix
   import mul_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      mul_op_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int K  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(K) + 1;

   if (!((BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8) && (XLEN % BITS_PER_CYCLE == 0))) begin : g_bad_cfg
      $error("mul_iterative_radix: BITS_PER_CYCLE must be 1, 2, 4 or 8 and divide XLEN");
   end

   mul_state_e        state_reg, state_next;
   mul_op_e           op_reg, op_next;
   logic [XLEN-1:0]   a_mag_reg, a_mag_next;
   logic [XLEN-1:0]   b_reg, b_next;
   logic              neg_reg, neg_next;
   logic [2*XLEN-1:0] acc_reg, acc_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [XLEN-1:0]   result_reg, result_next;

   mul_op_e           op_in;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [2*XLEN-1:0] step_acc;
   logic [2*XLEN-1:0] product;
   logic              reuse_hit;

   assign op_in = mul_op_e'(mul_op_i);

   // magnitudes; the most negative value maps onto itself as an unsigned magnitude
   assign a_neg = op_a_signed(op_in) & op_a_i[XLEN-1];
   assign b_neg = op_b_signed(op_in) & op_b_i[XLEN-1];
   assign a_abs = a_neg ? (~op_a_i + XLEN'(1)) : op_a_i;
   assign b_abs = b_neg ? (~op_b_i + XLEN'(1)) : op_b_i;

   assign product = neg_reg ? (~acc_reg + (2*XLEN)'(1)) : acc_reg;

   mul_radix_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .CW             (CW)
   ) u_step (
      .acc      (acc_reg),
      .a_mag    (a_mag_reg),
      .b_chunk  (b_reg[BITS_PER_CYCLE-1:0]),
      .count    (count_reg),
      .acc_next (step_acc)
   );

`ifdef MUL_PRODUCT_REUSE_EN
   logic [XLEN-1:0]   last_a_reg, last_a_next;
   logic [XLEN-1:0]   last_b_reg, last_b_next;
   mul_op_e           last_op_reg, last_op_next;
   logic [2*XLEN-1:0] last_prod_reg, last_prod_next;
   logic              last_valid_reg, last_valid_next;

   // MUL only needs the low half, which is identical for every signedness
   assign reuse_hit = last_valid_reg && (op_a_i == last_a_reg) && (op_b_i == last_b_reg) &&
                      ((op_in == MUL) || (op_in == last_op_reg));

   // stored operands/product of the last completed computation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_a_reg     <= '0;
         last_b_reg     <= '0;
         last_op_reg    <= MUL;
         last_prod_reg  <= '0;
         last_valid_reg <= 1'b0;
      end else begin
         last_a_reg     <= last_a_next;
         last_b_reg     <= last_b_next;
         last_op_reg    <= last_op_next;
         last_prod_reg  <= last_prod_next;
         last_valid_reg <= last_valid_next;
      end
   end
`else
   assign reuse_hit = 1'b0;
`endif

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         op_reg     <= MUL;
         a_mag_reg  <= '0;
         b_reg      <= '0;
         neg_reg    <= 1'b0;
         acc_reg    <= '0;
         count_reg  <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         a_mag_reg  <= a_mag_next;
         b_reg      <= b_next;
         neg_reg    <= neg_next;
         acc_reg    <= acc_next;
         count_reg  <= count_next;
         result_reg <= result_next;
      end
   end

   // next-state and datapath updates; flush overrides everything
   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      a_mag_next  = a_mag_reg;
      b_next      = b_reg;
      neg_next    = neg_reg;
      acc_next    = acc_reg;
      count_next  = count_reg;
      result_next = result_reg;
`ifdef MUL_PRODUCT_REUSE_EN
      last_a_next     = last_a_reg;
      last_b_next     = last_b_reg;
      last_op_next    = last_op_reg;
      last_prod_next  = last_prod_reg;
      last_valid_next = last_valid_reg;
`endif
      if (flush_i) begin
         state_next = IDLE;
`ifdef MUL_PRODUCT_REUSE_EN
         last_valid_next = 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start_i) begin
                  op_next = op_in;
                  if (reuse_hit) begin
                     state_next = DONE;
`ifdef MUL_PRODUCT_REUSE_EN
                     result_next = (op_in == MUL) ? last_prod_reg[XLEN-1:0]
                                                  : last_prod_reg[2*XLEN-1:XLEN];
`endif
                  end else begin
                     state_next = CALC;
                     a_mag_next = a_abs;
                     b_next     = b_abs;
                     neg_next   = a_neg ^ b_neg;
                     acc_next   = '0;
                     count_next = '0;
`ifdef MUL_PRODUCT_REUSE_EN
                     last_a_next     = op_a_i;
                     last_b_next     = op_b_i;
                     last_op_next    = op_in;
                     last_valid_next = 1'b0;
`endif
                  end
               end else begin
                  state_next = IDLE;
               end
            end
            CALC: begin
               acc_next   = step_acc;
               b_next     = b_reg >> BITS_PER_CYCLE;
               count_next = count_reg + CW'(1);
               if (count_reg == CW'(K - 1)) begin
                  state_next = SIGN;
               end
            end
            SIGN: begin
               result_next = (op_reg == MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
               state_next  = DONE;
`ifdef MUL_PRODUCT_REUSE_EN
               last_prod_next  = product;
               last_valid_next = 1'b1;
`endif
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign ready_o  = (state_reg == IDLE) || (state_reg == DONE);
   assign busy_o   = (state_reg == CALC) || (state_reg == SIGN);
   assign done_o   = (state_reg == DONE);
   assign result_o = result_reg;

endmodule
